// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC sequencer with branch redirect, stall and halt.
// Optional macro PC_BRANCH_COUNT_EN adds a saturating taken-branch counter.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   stall       hold pc, ignore imem_ack
//   br_valid    branch resolution valid
//   br_taken    branch taken (qualified by br_valid)
//   br_target   branch target address
//   halt        halt request
//   imem_ack    instruction word returned for pc
//   pc          registered fetch address
//   next_pc     pc + 4 (combinational)
//   imem_req    fetch request, high only while fetching
//   instr_valid one-cycle pulse, fetched word valid
//   flush       one-cycle pulse, squash younger instructions
//   halted      core halted
//   br_count    taken-branch count (PC_BRANCH_COUNT_EN only)

module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        halt,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic        imem_req,
  output logic        instr_valid,
  output logic        flush,
  output logic        halted
`ifdef PC_BRANCH_COUNT_EN
  ,
  output logic [15:0] br_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_FLUSH,
    S_HALTED
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_pc_inc;
  logic        r_ivalid;
  logic        w_ivalid_nxt;
  logic        r_flush;
  logic        w_flush_nxt;
  logic        r_halted;
  logic        w_halted_nxt;
  logic        w_fetch;
  logic        w_br_take;

  // 32-bit add wraps naturally at 2^32
  assign w_pc_inc  = r_pc + 32'd4;
  assign w_fetch   = (r_state == S_FETCH);
  assign w_br_take = w_fetch & br_valid & br_taken;

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_ivalid_nxt = 1'b0;
    w_flush_nxt  = 1'b0;
    w_halted_nxt = r_halted;
    unique case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        // taken branch beats halt, stall and ack
        if (w_br_take) begin
          w_pc_nxt    = {br_target[31:2], 2'b00};
          w_flush_nxt = 1'b1;
          w_state_nxt = S_FLUSH;
        end else if (halt) begin
          w_halted_nxt = 1'b1;
          w_state_nxt  = S_HALTED;
        end else if (!stall && imem_ack) begin
          w_pc_nxt     = w_pc_inc;
          w_ivalid_nxt = 1'b1;
        end
      end
      S_FLUSH: begin
        w_state_nxt = S_FETCH;
      end
      S_HALTED: begin
        w_halted_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_ivalid <= 1'b0;
      r_flush  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_ivalid <= w_ivalid_nxt;
      r_flush  <= w_flush_nxt;
      r_halted <= w_halted_nxt;
    end
  end

`ifdef PC_BRANCH_COUNT_EN
  logic [15:0] r_br_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_br_cnt <= 16'h0000;
    end else if (w_br_take && (r_br_cnt != 16'hFFFF)) begin
      r_br_cnt <= r_br_cnt + 16'd1;
    end
  end

  assign br_count = r_br_cnt;
`endif

  assign pc          = r_pc;
  assign next_pc     = w_pc_inc;
  assign imem_req    = w_fetch;
  assign instr_valid = r_ivalid;
  assign flush       = r_flush;
  assign halted      = r_halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks of pc_sequencer
// against a cycle-level behavioural model.

module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br_valid;
  logic        br_taken;
  logic [31:0] br_target;
  logic        halt;
  logic        imem_ack;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        imem_req;
  logic        instr_valid;
  logic        flush;
  logic        halted;
`ifdef PC_BRANCH_COUNT_EN
  logic [15:0] br_count;
`endif

  int checks;
  int errors;

  // model: fetching flag, pc, pulses, halt flag, branch count
  logic [31:0] m_pc;
  bit          m_req;
  bit          m_iv;
  bit          m_fl;
  bit          m_halted;
  logic [15:0] m_bc;

  pc_sequencer #(
    .RESET_PC(RST_PC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .br_valid   (br_valid),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .halt       (halt),
    .imem_ack   (imem_ack),
    .pc         (pc),
    .next_pc    (next_pc),
    .imem_req   (imem_req),
    .instr_valid(instr_valid),
    .flush      (flush),
    .halted     (halted)
`ifdef PC_BRANCH_COUNT_EN
    ,
    .br_count   (br_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time expired, required finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    stall     = 1'b0;
    br_valid  = 1'b0;
    br_taken  = 1'b0;
    br_target = 32'h0;
    halt      = 1'b0;
    imem_ack  = 1'b0;
  endtask

  task automatic model_reset();
    m_pc     = RST_PC;
    m_req    = 1'b0;
    m_iv     = 1'b0;
    m_fl     = 1'b0;
    m_halted = 1'b0;
    m_bc     = 16'h0;
  endtask

  // advance one clock and the model alongside it
  task automatic tick();
    logic [31:0] npc;
    bit          nreq;
    bit          niv;
    bit          nfl;
    bit          nh;
    logic [15:0] nbc;
    npc  = m_pc;
    nreq = m_req;
    niv  = 1'b0;
    nfl  = 1'b0;
    nh   = m_halted;
    nbc  = m_bc;
    if (!rst) begin
      npc  = RST_PC;
      nreq = 1'b0;
      nh   = 1'b0;
      nbc  = 16'h0;
    end else if (m_req) begin
      if (br_valid && br_taken) begin
        npc  = br_target & ~32'd3;
        nfl  = 1'b1;
        nreq = 1'b0;
        if (nbc != 16'hFFFF) nbc = nbc + 16'd1;
      end else if (halt) begin
        nh   = 1'b1;
        nreq = 1'b0;
      end else if (!stall && imem_ack) begin
        npc = m_pc + 32'd4;
        niv = 1'b1;
      end
    end else if (!m_halted) begin
      nreq = 1'b1;
    end
    @(posedge clk);
    #1;
    m_pc     = npc;
    m_req    = nreq;
    m_iv     = niv;
    m_fl     = nfl;
    m_halted = nh;
    m_bc     = nbc;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    model_reset();
    #2;
    rst = 1'b1;
  endtask

  // redirect to target, then let the flush gap pass
  task automatic go_to(input logic [31:0] t);
    clear_inputs();
    br_valid  = 1'b1;
    br_taken  = 1'b1;
    br_target = t;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (pc !== RST_PC || imem_req !== 1'b0 || instr_valid !== 1'b0 ||
        flush !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: pc=%h req=%b iv=%b fl=%b h=%b, required pc=%h and zeros",
               pc, imem_req, instr_valid, flush, halted, RST_PC);
    end
`ifdef PC_BRANCH_COUNT_EN
    checks++;
    if (br_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_brcount: got %h required 0000", br_count);
    end
`endif
    tick();
    rst      = 1'b1;
    imem_ack = 1'b1;
    tick();
    checks++;
    if (imem_req !== 1'b1 || pc !== 32'h100 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_req: req=%b pc=%h iv=%b, required 1 100 0",
               imem_req, pc, instr_valid);
    end
    tick();
    checks++;
    if (pc !== 32'h104 || instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_ack: pc=%h iv=%b, required 104 1", pc, instr_valid);
    end
    imem_ack = 1'b0;
    tick();
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulse_width: iv=%b required 0", instr_valid);
    end
  endtask

  task automatic test_stall();
    go_to(32'h20);
    stall    = 1'b1;
    imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc !== 32'h20 || instr_valid !== 1'b0 || imem_req !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: pc=%h iv=%b req=%b, required 20 0 1",
                 i, pc, instr_valid, imem_req);
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if (pc !== 32'h24 || instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: pc=%h iv=%b, required 24 1", pc, instr_valid);
    end
  endtask

  task automatic test_taken_branch();
    do_reset();
    tick();
    br_valid  = 1'b1;
    br_taken  = 1'b1;
    br_target = 32'h403;
    stall     = 1'b1;
    halt      = 1'b1;
    imem_ack  = 1'b1;
    tick();
    checks++;
    if (pc !== 32'h400 || flush !== 1'b1 || imem_req !== 1'b0 ||
        halted !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL taken_redirect: pc=%h fl=%b req=%b h=%b iv=%b, required 400 1 0 0 0",
               pc, flush, imem_req, halted, instr_valid);
    end
`ifdef PC_BRANCH_COUNT_EN
    checks++;
    if (br_count !== 16'd1) begin
      errors++;
      $display("FAIL taken_brcount: got %h required 0001", br_count);
    end
`endif
    clear_inputs();
    tick();
    checks++;
    if (flush !== 1'b0 || imem_req !== 1'b1 || halted !== 1'b0 || pc !== 32'h400) begin
      errors++;
      $display("FAIL taken_after: fl=%b req=%b h=%b pc=%h, required 0 1 0 400",
               flush, imem_req, halted, pc);
    end
  endtask

  task automatic test_not_taken();
    go_to(32'h40);
    br_valid  = 1'b1;
    br_taken  = 1'b0;
    br_target = 32'h800;
    imem_ack  = 1'b1;
    tick();
    checks++;
    if (pc !== 32'h44 || flush !== 1'b0 || instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL not_taken: pc=%h fl=%b iv=%b, required 44 0 1", pc, flush, instr_valid);
    end
    clear_inputs();
  endtask

  task automatic test_wrap_halt();
    go_to(32'hFFFF_FFFC);
    checks++;
    if (next_pc !== 32'h0) begin
      errors++;
      $display("FAIL wrap_next_pc: got %h required 00000000", next_pc);
    end
    imem_ack = 1'b1;
    tick();
    checks++;
    if (pc !== 32'h0) begin
      errors++;
      $display("FAIL wrap_pc: got %h required 00000000", pc);
    end
    imem_ack = 1'b0;
    halt     = 1'b1;
    tick();
    checks++;
    if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h0) begin
      errors++;
      $display("FAIL halt_enter: h=%b req=%b pc=%h, required 1 0 0", halted, imem_req, pc);
    end
    halt      = 1'b0;
    br_valid  = 1'b1;
    br_taken  = 1'b1;
    br_target = 32'h500;
    imem_ack  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (halted !== 1'b1 || pc !== 32'h0 || flush !== 1'b0 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL halt_sticky[%0d]: h=%b pc=%h fl=%b req=%b, required 1 0 0 0",
                 i, halted, pc, flush, imem_req);
      end
    end
    do_reset();
    checks++;
    if (halted !== 1'b0 || pc !== RST_PC) begin
      errors++;
      $display("FAIL halt_reset: h=%b pc=%h, required 0 %h", halted, pc, RST_PC);
    end
  endtask

  task automatic test_reset_midflight();
    tick();
    br_valid  = 1'b1;
    br_taken  = 1'b1;
    br_target = 32'h9000;
    tick();
    clear_inputs();
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (flush !== 1'b0 || pc !== RST_PC) begin
      errors++;
      $display("FAIL midflight_abort: fl=%b pc=%h, required 0 %h", flush, pc, RST_PC);
    end
    rst      = 1'b1;
    imem_ack = 1'b1;
    tick();
    checks++;
    if (flush !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL midflight_quiet: fl=%b iv=%b, required 0 0", flush, instr_valid);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b1 || pc !== RST_PC + 32'd4) begin
      errors++;
      $display("FAIL midflight_resume: iv=%b pc=%h, required 1 %h",
               instr_valid, pc, RST_PC + 32'd4);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    int hcnt;
    hcnt = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      stall     = ($urandom % 4) == 0;
      br_valid  = ($urandom % 5) == 0;
      br_taken  = $urandom % 2;
      br_target = $urandom;
      if (($urandom % 8) == 0) br_target = 32'hFFFF_FFF0 | ($urandom % 16);
      halt      = ($urandom % 90) == 0;
      imem_ack  = ($urandom % 4) != 0;
      if (m_halted) hcnt++;
      if (($urandom % 300) == 0 || hcnt > 12) begin
        hcnt = 0;
        rst  = 1'b0;
        model_reset();
        #1;
        rst = 1'b1;
      end
      tick();
      checks++;
      if (pc !== m_pc || next_pc !== m_pc + 32'd4 || imem_req !== m_req ||
          instr_valid !== m_iv || flush !== m_fl || halted !== m_halted) begin
        errors++;
        $display("FAIL random[%0d]: pc=%h/%h npc=%h req=%b/%b iv=%b/%b fl=%b/%b h=%b/%b (got/required)",
                 c, pc, m_pc, next_pc, imem_req, m_req, instr_valid, m_iv,
                 flush, m_fl, halted, m_halted);
      end
`ifdef PC_BRANCH_COUNT_EN
      checks++;
      if (br_count !== m_bc) begin
        errors++;
        $display("FAIL random_brcount[%0d]: got %h required %h", c, br_count, m_bc);
      end
`endif
    end
    clear_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    model_reset();
    rst = 1'b0;
    #12;
    test_reset();
    test_stall();
    test_taken_branch();
    test_not_taken();
    test_wrap_halt();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
